// File: rtl/pll_led_monitor_if.sv
// Control/readout bundle for the LED frequency monitor.
// The master side (bench or debug logic) drives led, start and rd_sel.
// The slave side (the monitor) returns status and the selected result.
interface pll_led_monitor_if #(
  parameter int CHANNELS  = 7,
  parameter int CNT_WIDTH = 16
);
  logic [CHANNELS-1:0]  led;
  logic                 start;
  logic                 busy;
  logic                 done;
  logic [2:0]           rd_sel;
  logic [CNT_WIDTH-1:0] rd_count;
  logic                 rd_sat;
  logic [CHANNELS-1:0]  active;

  modport master (
    output led, start, rd_sel,
    input  busy, done, rd_count, rd_sat, active
  );

  modport slave (
    input  led, start, rd_sel,
    output busy, done, rd_count, rd_sat, active
  );
endinterface

// File: rtl/pll_led_monitor.sv
// LED frequency monitor.
// Counts rising edges on each led input over a fixed gate window, then
// latches the per-channel counts and saturation flags for readout.

// Per-channel path: input synchronizer, rise detector, saturating working
// counter and the latched result.
module pll_led_monitor_chan #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 led,
  input  logic                 clr,
  input  logic                 cnt_en,
  input  logic                 capture,
  output logic [CNT_WIDTH-1:0] res_cnt,
  output logic                 res_sat
);
  logic                 s1, s2, p;
  logic                 rise;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic                 sat, sat_nxt;

  assign rise = s2 & ~p;

  // Next working count; at full scale a further rise only sets the sat flag.
  always_comb begin
    cnt_nxt = cnt;
    sat_nxt = sat;
    if (cnt_en && rise) begin
      if (cnt == '1) sat_nxt = 1'b1;
      else           cnt_nxt = cnt + 1'b1;
    end
  end

  // Synchronizer runs in every state; the capture takes the next value so an
  // edge in the final gate cycle is included.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      p       <= 1'b0;
      cnt     <= '0;
      sat     <= 1'b0;
      res_cnt <= '0;
      res_sat <= 1'b0;
    end else begin
      s1 <= led;
      s2 <= s1;
      p  <= s2;
      if (clr) begin
        cnt <= '0;
        sat <= 1'b0;
      end else begin
        cnt <= cnt_nxt;
        sat <= sat_nxt;
      end
      if (capture) begin
        res_cnt <= cnt_nxt;
        res_sat <= sat_nxt;
      end
    end
  end
endmodule

module pll_led_monitor #(
  parameter int CHANNELS    = 7,
  parameter int GATE_CYCLES = 1000,
  parameter int CNT_WIDTH   = 16
) (
  input logic              clk,
  input logic              RST,
  pll_led_monitor_if.slave bus
);
  localparam int            GW        = $clog2(GATE_CYCLES + 1);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ARM, GATE, DONE} state_t;

  state_t               state, state_nxt;
  logic [1:0]           arm_cnt;
  logic [GW-1:0]        gate_cnt;
  logic                 clr, cnt_en, capture;
  logic [CHANNELS-1:0][CNT_WIDTH-1:0] res_cnt;
  logic [CHANNELS-1:0]  res_sat;
  logic [CNT_WIDTH-1:0] rd_count;
  logic                 rd_sat;

  // State register plus ARM/GATE cycle counters; each counter idles at 0
  // outside its own state so it starts fresh on entry.
  always_ff @(posedge clk) begin
    if (RST) begin
      state    <= IDLE;
      arm_cnt  <= '0;
      gate_cnt <= '0;
    end else begin
      state    <= state_nxt;
      arm_cnt  <= (state == ARM)  ? arm_cnt + 2'd1   : 2'd0;
      gate_cnt <= (state == GATE) ? gate_cnt + 1'b1  : '0;
    end
  end

  // Next state and per-channel strobes.
  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    cnt_en    = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: if (bus.start) begin
        state_nxt = ARM;
        clr       = 1'b1;
      end
      ARM:  if (arm_cnt == 2'd2) state_nxt = GATE;
      GATE: begin
        cnt_en = 1'b1;
        if (gate_cnt == GATE_LAST) begin
          state_nxt = DONE;
          capture   = 1'b1;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    pll_led_monitor_chan #(.CNT_WIDTH(CNT_WIDTH)) u_chan (
      .clk     (clk),
      .rst     (RST),
      .led     (bus.led[i]),
      .clr     (clr),
      .cnt_en  (cnt_en),
      .capture (capture),
      .res_cnt (res_cnt[i]),
      .res_sat (res_sat[i])
    );
    assign bus.active[i] = |res_cnt[i];
  end

  // Readout mux; selects beyond the channel count read as zero.
  always_comb begin
    rd_count = '0;
    rd_sat   = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (bus.rd_sel == 3'(i)) begin
        rd_count = res_cnt[i];
        rd_sat   = res_sat[i];
      end
    end
  end

  assign bus.rd_count = rd_count;
  assign bus.rd_sat   = rd_sat;
  assign bus.busy     = (state != IDLE);
  assign bus.done     = (state == DONE);
endmodule

// File: tb/tb_pll_led_monitor.sv
// Bench for pll_led_monitor: a default instance plus a small one
// (CNT_WIDTH=4, GATE_CYCLES=100) for the saturation case.
module tb_pll_led_monitor;
  localparam int CH = 7;

  logic clk = 1'b0;
  logic RST = 1'b1;
  always #5 clk = ~clk;

  pll_led_monitor_if #(.CHANNELS(CH), .CNT_WIDTH(16)) ifa ();
  pll_led_monitor_if #(.CHANNELS(CH), .CNT_WIDTH(4))  ifb ();

  pll_led_monitor #(.CHANNELS(CH), .GATE_CYCLES(1000), .CNT_WIDTH(16)) dut (
    .clk(clk), .RST(RST), .bus(ifa.slave));
  pll_led_monitor #(.CHANNELS(CH), .GATE_CYCLES(100), .CNT_WIDTH(4)) dut_small (
    .clk(clk), .RST(RST), .bus(ifb.slave));

  logic          start = 1'b0;
  logic [2:0]    rd_sel = 3'd0;
  bit            use_small = 1'b0;
  logic [CH-1:0] led_q = '0;
  int            half [CH] = '{default: 0};
  logic          lvl  [CH] = '{default: 1'b0};
  int            hc   [CH] = '{default: 0};
  bit            pulse_at [0:3000];

  assign ifa.led    = led_q;
  assign ifb.led    = led_q;
  assign ifa.start  = start & ~use_small;
  assign ifb.start  = start & use_small;
  assign ifa.rd_sel = rd_sel;
  assign ifb.rd_sel = rd_sel;

  logic [15:0]   o_cnt;
  logic          o_sat, o_busy, o_done;
  logic [CH-1:0] o_active;
  assign o_cnt    = use_small ? 16'(ifb.rd_count) : ifa.rd_count;
  assign o_sat    = use_small ? ifb.rd_sat  : ifa.rd_sat;
  assign o_busy   = use_small ? ifb.busy    : ifa.busy;
  assign o_done   = use_small ? ifb.done    : ifa.done;
  assign o_active = use_small ? ifb.active  : ifa.active;

  // LED generator: half[i]=0 holds lvl[i], otherwise toggles every half[i] clks.
  always @(negedge clk) begin
    for (int i = 0; i < CH; i++) begin
      if (half[i] == 0) begin
        hc[i]    = 0;
        led_q[i] = lvl[i];
      end else begin
        hc[i]++;
        if (hc[i] >= half[i]) begin
          hc[i]    = 0;
          led_q[i] = ~led_q[i];
        end
      end
    end
  end

  typedef struct {
    string tag;
    int    ch;
    int    lo;
    int    hi;
    bit    sat;
  } exp_t;

  exp_t sb [$];
  int   exp_lo [CH], exp_hi [CH];
  bit   exp_sat [CH];
  int   checks = 0, errors = 0;
  int   cyc = 0;
  int   dc;
  bit   saw_done;

  task automatic chk_eq(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(string tag, int obs, int lo, int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic exp_zero();
    for (int i = 0; i < CH; i++) begin
      exp_lo[i] = 0; exp_hi[i] = 0; exp_sat[i] = 1'b0;
    end
  endtask

  task automatic push_meas(string tag);
    for (int i = 0; i < CH; i++)
      sb.push_back('{tag: tag, ch: i, lo: exp_lo[i], hi: exp_hi[i], sat: exp_sat[i]});
  endtask

  // Pop every pending expectation and compare against the result readout.
  task automatic readout();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rd_sel = 3'(e.ch);
      #1;
      chk_rng($sformatf("%s_cnt%0d", e.tag, e.ch), int'(o_cnt), e.lo, e.hi);
      chk_eq($sformatf("%s_sat%0d", e.tag, e.ch), 32'(o_sat), 32'(e.sat));
      chk_eq($sformatf("%s_act%0d", e.tag, e.ch), 32'(o_active[e.ch]), 32'(e.lo > 0));
    end
  endtask

  // Start is sampled at the edge closing cycle 0; returns #1 into cycle 1.
  task automatic launch(string tag);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc   = 1;
    chk_eq({tag, "_busy_c1"}, 32'(o_busy), 32'd1);
  endtask

  // Waits (bounded) for done; reports the cycle it was first seen, -1 if never.
  task automatic wait_done(output int dcyc);
    dcyc = -1;
    while (cyc < 3000) begin
      start = pulse_at[cyc];
      if (o_done === 1'b1) begin
        dcyc = cyc;
        break;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic finish_meas(string tag, int exp_dc);
    int d;
    wait_done(d);
    chk_eq({tag, "_done_cyc"}, d, exp_dc);
    @(posedge clk);
    #1;
    chk_eq({tag, "_busy_fall"}, 32'(o_busy), 32'd0);
    chk_eq({tag, "_done_fall"}, 32'(o_done), 32'd0);
    readout();
  endtask

  task automatic run(string tag, int exp_dc);
    push_meas(tag);
    launch(tag);
    finish_meas(tag, exp_dc);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_eq("rst_busy",   32'(o_busy),   32'd0);
    chk_eq("rst_done",   32'(o_done),   32'd0);
    chk_eq("rst_active", 32'(o_active), 32'd0);
    chk_eq("rst_cnt",    32'(o_cnt),    32'd0);
    chk_eq("rst_sat",    32'(o_sat),    32'd0);
    @(negedge clk);
    RST = 1'b0;

    // Period-10 LED on channel 0
    half[0] = 5;
    repeat (20) @(posedge clk);
    exp_zero();
    exp_lo[0] = 100; exp_hi[0] = 100;
    run("t1", 1004);

    // Reset at gate cycle 500 clears the prior result and produces no done
    launch("t4");
    saw_done = 1'b0;
    while (cyc < 504) begin
      @(posedge clk);
      #1;
      cyc++;
      saw_done |= o_done;
    end
    RST = 1'b1;
    @(posedge clk);
    #1;
    RST = 1'b0;
    chk_eq("t4_no_done", 32'(saw_done | o_done), 32'd0);
    chk_eq("t4_busy",    32'(o_busy),   32'd0);
    chk_eq("t4_active",  32'(o_active), 32'd0);
    exp_zero();
    push_meas("t4_clr");
    readout();
    exp_lo[0] = 100; exp_hi[0] = 100;
    run("t4_next", 1004);

    // Static LEDs, plus an edge injected only during ARM
    half[0] = 0;
    for (int i = 0; i < CH; i++) lvl[i] = 1'b0;
    repeat (8) @(posedge clk);
    exp_zero();
    push_meas("t2_low");
    launch("t2_low");
    lvl[2] = 1'b1;
    finish_meas("t2_low", 1004);
    for (int i = 0; i < CH; i++) lvl[i] = 1'b1;
    repeat (8) @(posedge clk);
    run("t2_high", 1004);

    // Start re-pulsed while busy is ignored; start right after DONE is taken
    half[0] = 5;
    repeat (20) @(posedge clk);
    exp_zero();
    exp_lo[0] = 100; exp_hi[0] = 100;
    pulse_at[2] = 1'b1; pulse_at[200] = 1'b1; pulse_at[1004] = 1'b1;
    push_meas("t5_a");
    launch("t5_a");
    wait_done(dc);
    chk_eq("t5_done_cyc", dc, 1004);
    pulse_at[2] = 1'b0; pulse_at[200] = 1'b0; pulse_at[1004] = 1'b0;
    @(posedge clk);
    #1;
    chk_eq("t5_busy_1005", 32'(o_busy), 32'd0);
    chk_eq("t5_done_1005", 32'(o_done), 32'd0);
    readout();
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc   = 1;
    chk_eq("t5_busy_1006", 32'(o_busy), 32'd1);
    push_meas("t5_b");
    finish_meas("t5_b", 1004);

    // Seven channels at periods 2..128
    for (int i = 0; i < CH; i++) half[i] = 1 << i;
    repeat (20) @(posedge clk);
    exp_lo = '{500, 250, 125, 62, 31, 15, 7};
    exp_hi = '{500, 250, 125, 63, 32, 16, 8};
    run("t6", 1004);
    rd_sel = 3'd7;
    #1;
    chk_eq("t6_sel7_cnt", 32'(o_cnt), 32'd0);
    chk_eq("t6_sel7_sat", 32'(o_sat), 32'd0);

    // Saturation on the small instance, then a clean follow-up
    use_small = 1'b1;
    for (int i = 0; i < CH; i++) begin half[i] = 0; lvl[i] = 1'b0; end
    half[1] = 1;
    repeat (10) @(posedge clk);
    exp_zero();
    exp_lo[1] = 15; exp_hi[1] = 15; exp_sat[1] = 1'b1;
    run("t3_sat", 104);
    half[1] = 0;
    repeat (10) @(posedge clk);
    exp_zero();
    run("t3_clr", 104);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
